// File: rtl/issue_scoreboard_pkg.sv
// Shared ISA types for the issue stage: register classes, register indices
// and the decoded-instruction record handed from decode to execute.
package issue_scoreboard_pkg;

    localparam int NUM_CLASSES = 3;
    localparam int NUM_REGS    = 32;

    typedef enum logic [1:0] {
        CLASS_SCALAR = 2'd0,
        CLASS_FP     = 2'd1,
        CLASS_VEC    = 2'd2
    } reg_class_e;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic       is_valid;
        logic [7:0] op;
        logic       uses_rs1;
        reg_class_e rs1_class;
        reg_idx_t   rs1;
        logic       uses_rs2;
        reg_class_e rs2_class;
        reg_idx_t   rs2;
        logic       uses_rd;
        reg_class_e rd_class;
        reg_idx_t   rd;
    } decode_ctrl_t;

    // Scalar x0 is hardwired to zero, so it is never tracked as busy.
    function automatic logic is_scalar_x0(input reg_class_e cls, input reg_idx_t idx);
        return (cls == CLASS_SCALAR) && (idx == 5'd0);
    endfunction

endpackage

// File: rtl/scoreboard_bank.sv
// Per-class busy vectors with set/clear update and the RAW/WAW hazard lookup
// for the instruction currently offered by decode.
module scoreboard_bank
    import issue_scoreboard_pkg::*;
#(
    parameter int NUM_WB = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decode_ctrl_t            lookup_ctrl,
    output logic                    hazard,
    input  logic                    set_en,
    input  reg_class_e              set_class,
    input  reg_idx_t                set_idx,
    input  logic                    clr_en,
    input  reg_class_e              clr_class,
    input  reg_idx_t                clr_idx,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  reg_class_e [NUM_WB-1:0] wb_class,
    input  reg_idx_t [NUM_WB-1:0]   wb_rd,
    output logic                    busy_any
);

    logic [NUM_CLASSES-1:0][NUM_REGS-1:0] busy_all;
    logic [NUM_CLASSES-1:0][NUM_REGS-1:0] eff_all;

    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
        localparam logic [1:0] CLS = 2'(gi);

        logic [NUM_REGS-1:0] busy_q;
        logic [NUM_REGS-1:0] busy_d;
        logic [NUM_REGS-1:0] wb_mask;
        logic [NUM_REGS-1:0] clr_mask;
        logic [NUM_REGS-1:0] set_mask;

        always_comb begin
            wb_mask = '0;
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_valid[w] && (wb_class[w] == CLS)) begin
                    wb_mask[wb_rd[w]] = 1'b1;
                end
            end
            clr_mask = wb_mask;
            if (clr_en && (clr_class == CLS)) begin
                clr_mask[clr_idx] = 1'b1;
            end
            set_mask = '0;
            if (set_en && (set_class == CLS) && !is_scalar_x0(set_class, set_idx)) begin
                set_mask[set_idx] = 1'b1;
            end
            // A same-cycle set wins over any clear of the same bit.
            busy_d = (busy_q & ~clr_mask) | set_mask;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                busy_q <= '0;
            end else begin
                busy_q <= busy_d;
            end
        end

        assign busy_all[gi] = busy_q;
        assign eff_all[gi]  = busy_q & ~wb_mask;
    end

    function automatic logic lookup_busy(
        input logic [NUM_CLASSES-1:0][NUM_REGS-1:0] vec,
        input reg_class_e                           cls,
        input reg_idx_t                             idx
    );
        logic [NUM_REGS-1:0] row;
        case (cls)
            CLASS_SCALAR: row = vec[0];
            CLASS_FP:     row = vec[1];
            CLASS_VEC:    row = vec[2];
            default:      row = '0;
        endcase
        return row[idx] && !is_scalar_x0(cls, idx);
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (lookup_ctrl.is_valid) begin
            hazard = (lookup_ctrl.uses_rs1 && lookup_busy(eff_all, lookup_ctrl.rs1_class, lookup_ctrl.rs1))
                  || (lookup_ctrl.uses_rs2 && lookup_busy(eff_all, lookup_ctrl.rs2_class, lookup_ctrl.rs2))
                  || (lookup_ctrl.uses_rd  && lookup_busy(eff_all, lookup_ctrl.rd_class,  lookup_ctrl.rd));
        end
    end

    assign busy_any = |busy_all;

endmodule

// File: rtl/issue_scoreboard.sv
// Single-entry issue register guarded by a register scoreboard: holds decode
// back on RAW/WAW hazards, backpressure or flush, and counts stalled cycles.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NUM_WB      = 2,
    parameter int STALL_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  decode_ctrl_t            in_ctrl,
    output logic                    in_ready,
    output logic                    out_valid,
    output decode_ctrl_t            out_ctrl,
    input  logic                    out_ready,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  reg_class_e [NUM_WB-1:0] wb_class,
    input  reg_idx_t [NUM_WB-1:0]   wb_rd,
    input  logic                    flush,
    output logic                    busy_any,
    output logic [STALL_CNT_W-1:0]  stall_cnt
);

    logic                   out_valid_q;
    logic                   out_valid_d;
    decode_ctrl_t           out_ctrl_q;
    decode_ctrl_t           out_ctrl_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;
    logic                   hazard;
    logic                   accept;
    logic                   set_en;
    logic                   clr_en;

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign set_en   = accept && in_ctrl.is_valid && in_ctrl.uses_rd;
    // A flushed instruction will never write back, so release its destination.
    assign clr_en   = flush && out_valid_q && out_ctrl_q.is_valid && out_ctrl_q.uses_rd;

    scoreboard_bank #(
        .NUM_WB (NUM_WB)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .lookup_ctrl (in_ctrl),
        .hazard      (hazard),
        .set_en      (set_en),
        .set_class   (in_ctrl.rd_class),
        .set_idx     (in_ctrl.rd),
        .clr_en      (clr_en),
        .clr_class   (out_ctrl_q.rd_class),
        .clr_idx     (out_ctrl_q.rd),
        .wb_valid    (wb_valid),
        .wb_class    (wb_class),
        .wb_rd       (wb_rd),
        .busy_any    (busy_any)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && !in_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign stall_cnt = stall_cnt_q;

endmodule
